apb_cmd_master: RTL
===================

Name: apb_cmd_master

Overview:
- RTL APB initiator that turns a simple valid/ready command stream into APB2/APB3 transfers toward slaves such as the GPIO controller.
- Lets on-chip logic drive the port, output, direction and interrupt-mask registers without a CPU or bench driver.
- One outstanding transfer at a time. The result of each transfer is returned on a valid/ready response channel.
- Adds a programmable pready timeout so a hung slave cannot stall the requester.

Parameters:
- ADDR_W, 32, width of cmd_addr/paddr.
- DATA_W, 32, width of write/read data.
- TIMEOUT, 16, maximum ACCESS cycles waiting for pready before abort; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target byte address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for aborted transfers.
- rsp_err  out  1  pslverr seen or timeout.
- rsp_timeout  out  1  abort caused by timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- paddr  out  ADDR_W  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data; 0 during reads.
- prdata  in  DATA_W  APB read data.
- pready  in  1  slave ready.
- pslverr  in  1  slave error.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0 from the next edge: psel, penable, paddr, pwrite, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, and the timeout counter.
  - cmd_ready is 0 while rstn=0.
  - A transfer in progress is dropped with no response; psel falls on that edge even mid-ACCESS.
- The FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1 (combinational on state; does not depend on cmd_valid).
  - On cmd_valid&cmd_ready, register cmd_addr/cmd_write/cmd_wdata into paddr/pwrite/pwdata, and go to SETUP.
  - pwdata is forced to 0 when cmd_write=0.
- SETUP (one cycle): psel=1, penable=0, then go to ACCESS. Clear the counter.
- ACCESS: psel=1, penable=1. paddr/pwrite/pwdata stay stable through SETUP and ACCESS.
  - pready=1: capture rsp_rdata=prdata (reads only, else 0), rsp_err=pslverr, rsp_timeout=0. Deassert psel/penable and go to RESP.
  - pready=0: increment the counter.
  - TIMEOUT≠0 and counter reaches TIMEOUT-1 with pready still 0: abort. Deassert psel/penable, rsp_rdata=0, rsp_err=1, rsp_timeout=1, go to RESP.
  - pready=1 on the abort cycle wins: normal completion.
- RESP:
  - rsp_valid=1; the rsp_* fields stay stable until rsp_valid&rsp_ready.
  - On handshake, go to IDLE and clear rsp_valid.
  - cmd_ready=0 in RESP; there is no command/response overlap.
- Latency with zero wait states: command accepted at edge N → SETUP cycle N+1 → ACCESS cycle N+2 → rsp_valid=1 at N+3.
- Back-to-back minimum: a new command is accepted in the cycle after the response handshake, so one APB transfer occupies at least 4 cycles.
- cmd_* may change freely when no handshake occurs. rsp_ready is ignored outside RESP.
- Timeout example: TIMEOUT=16 gives a maximum of 16 ACCESS cycles (including the first) before abort.
- APB protocol guarantees: penable is never 1 without psel, and psel is never asserted outside SETUP/ACCESS.
- Counter saturates. No wrap-around is possible when TIMEOUT=0.

Test Plan:
- Write 0xFF to 0x08 with pready tied 1: SETUP is observed (psel=1, penable=0, paddr=0x08, pwrite=1, pwdata=0xFF), then ACCESS is observed. rsp_valid rises 3 cycles after the accept, with rsp_err=0 and rsp_rdata=0.
- Read 0x00 with the slave returning prdata=0xA5 after 3 wait states: penable stays high for 4 cycles, rsp_rdata=0xA5, pwdata=0 throughout, rsp_err=0.
- Write with pslverr=1 on the pready cycle: rsp_err=1, rsp_timeout=0, and the FSM returns to IDLE after rsp_ready.
- pready stuck 0 with TIMEOUT=16: psel drops after exactly 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with TIMEOUT=0: still waiting at 1000 cycles.
- rsp_ready held 0 for 5 cycles while cmd_valid=1: cmd_ready=0 and rsp fields are stable throughout. After rsp_ready=1, the next command is accepted one cycle later.
- rstn=0 for one cycle in mid-ACCESS: psel/penable/rsp_valid are 0 on the next edge and no response is produced. A subsequent command to 0x04 with data 0x55 completes normally.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB2/APB3 initiator: converts a valid/ready command stream into single APB
// transfers and returns each result on a valid/ready response channel.
module apb_cmd_master #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;

   assign cmd_ready   = rstn && (state == IDLE);
   assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         paddr       <= '0;
         pwrite      <= 1'b0;
         pwdata      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  paddr   <= cmd_addr;
                  pwrite  <= cmd_write;
                  pwdata  <= cmd_write ? cmd_wdata : '0;
                  psel    <= 1'b1;
                  penable <= 1'b0;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               penable  <= 1'b1;
               wait_cnt <= '0;
               state    <= ACCESS;
            end
            ACCESS: begin
               // pready takes priority over a timeout landing in the same cycle
               if (pready) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_rdata   <= pwrite ? '0 : prdata;
                  rsp_err     <= pslverr;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else if (timeout_hit) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else if (wait_cnt != '1) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
